// File: rtl/fpu_pkg.sv
// Shared FPU definitions: control codes, default long-op latencies,
// lane select and scheduler state encodings.
package fpu_pkg;

    localparam int CW_DEF = 5;

    // E-stage FPU control codes
    localparam logic [4:0] FNOP   = 5'b00000;
    localparam logic [4:0] FADD   = 5'b00001;
    localparam logic [4:0] FSUB   = 5'b00010;
    localparam logic [4:0] FMUL   = 5'b00011;
    localparam logic [4:0] FMADD  = 5'b00100;
    localparam logic [4:0] FMSUB  = 5'b00101;
    localparam logic [4:0] FNEG   = 5'b00110;
    localparam logic [4:0] FDIV   = 5'b00111;
    localparam logic [4:0] FMOV   = 5'b01000;
    localparam logic [4:0] FABS   = 5'b01001;
    localparam logic [4:0] FCMP   = 5'b01010;
    localparam logic [4:0] FCVT   = 5'b01011;
    localparam logic [4:0] FCEIL  = 5'b01100;
    localparam logic [4:0] FSQRT  = 5'b01101;
    localparam logic [4:0] FLOOR  = 5'b01110;

    // Shared divide/sqrt unit latencies (unit_start to result valid)
    localparam int DIV_LAT_DEF  = 3;
    localparam int SQRT_LAT_DEF = 2;

    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } sched_state_e;

    function automatic int max_lat(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fpu_longop_scheduler_if.sv
// Pipeline <-> long-op scheduler signal bundle. The pipeline side is the
// master (drives lane controls and abort); the scheduler is the slave.
interface fpu_longop_scheduler_if #(
    parameter int CW = 5
) ();
    logic [CW-1:0] fpuctl1;
    logic [CW-1:0] fpuctl2;
    logic          abort;
    logic          stall;
    logic          unit_start;
    logic          unit_op;
    logic          unit_sel;
    logic          cap1;
    logic          cap2;
    logic          use_kept1;
    logic          read_data_keep;
    logic          fstalled;

    modport master (
        output fpuctl1, fpuctl2, abort,
        input  stall, unit_start, unit_op, unit_sel, cap1, cap2,
               use_kept1, read_data_keep, fstalled
    );

    modport slave (
        input  fpuctl1, fpuctl2, abort,
        output stall, unit_start, unit_op, unit_sel, cap1, cap2,
               use_kept1, read_data_keep, fstalled
    );
endinterface

// File: rtl/fpu_longop_decode.sv
// Per-lane decode of an FPU control code into long-op flag, op select
// (0 = fdiv, 1 = fsqrt) and the unit latency for that op.
module fpu_longop_decode
    import fpu_pkg::*;
#(
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int SQRT_LAT = SQRT_LAT_DEF,
    parameter int CW       = CW_DEF,
    parameter int LW       = 2
) (
    input  logic [CW-1:0] i_code,
    output logic          o_is_long,
    output logic          o_op,
    output logic [LW-1:0] o_lat
);
    logic w_div;
    logic w_sqrt;

    assign w_div  = (i_code == CW'(FDIV));
    assign w_sqrt = (i_code == CW'(FSQRT));

    // Non-long codes report zero latency; callers gate on o_is_long.
    always_comb begin
        o_is_long = w_div | w_sqrt;
        o_op      = w_sqrt;
        o_lat     = '0;
        if (w_div)       o_lat = LW'(DIV_LAT);
        else if (w_sqrt) o_lat = LW'(SQRT_LAT);
    end
endmodule

// File: rtl/fpu_longop_scheduler.sv
// Serialises lane-1/lane-2 fdiv/fsqrt onto one shared non-pipelined unit,
// holding the float stall until every long op of the E bundle has a result.
// Lane 1 wins when both lanes issue; its result is kept while lane 2 runs.
// DIV_LAT and SQRT_LAT must both be >= 1.
module fpu_longop_scheduler
    import fpu_pkg::*;
#(
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int SQRT_LAT = SQRT_LAT_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    fpu_longop_scheduler_if.slave  bus
);
    localparam int NUM_LANES = 2;
    localparam int MAXL      = max_lat(DIV_LAT, SQRT_LAT);
    localparam int LW        = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

    logic [NUM_LANES-1:0][CW-1:0] w_code;
    logic [NUM_LANES-1:0]         w_is_long;
    logic [NUM_LANES-1:0]         w_op;
    logic [NUM_LANES-1:0][LW-1:0] w_lat;

    sched_state_e r_state, w_state_n;
    logic [LW-1:0] r_cnt, w_cnt_n;
    lane_e         r_cur, w_cur_n;
    logic          r_pend, w_pend_n;
    logic          r_kept1, w_kept1_n;
    logic          r_fstalled;

    logic w_stall, w_start, w_uop, w_usel, w_cap1, w_cap2, w_use_kept1, w_rdk;

    assign w_code[0] = bus.fpuctl1;
    assign w_code[1] = bus.fpuctl2;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            fpu_longop_decode #(
                .DIV_LAT  (DIV_LAT),
                .SQRT_LAT (SQRT_LAT),
                .CW       (CW),
                .LW       (LW)
            ) u_dec (
                .i_code    (w_code[g]),
                .o_is_long (w_is_long[g]),
                .o_op      (w_op[g]),
                .o_lat     (w_lat[g])
            );
        end
    endgenerate

    // Next-state and output decode; reset/abort silence every output and
    // drop any in-flight result so a late unit completion is never captured.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_cur_n     = r_cur;
        w_pend_n    = r_pend;
        w_kept1_n   = r_kept1;
        w_stall     = 1'b0;
        w_start     = 1'b0;
        w_uop       = 1'b0;
        w_usel      = 1'b0;
        w_cap1      = 1'b0;
        w_cap2      = 1'b0;
        w_use_kept1 = 1'b0;
        w_rdk       = 1'b0;
        if (!rstn || bus.abort) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_pend_n  = 1'b0;
            w_kept1_n = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_is_long) begin
                        w_cur_n   = w_is_long[0] ? LANE1 : LANE2;
                        w_stall   = 1'b1;
                        w_rdk     = 1'b1;
                        w_start   = 1'b1;
                        w_uop     = w_is_long[0] ? w_op[0] : w_op[1];
                        w_usel    = ~w_is_long[0];
                        w_cnt_n   = (w_is_long[0] ? w_lat[0] : w_lat[1]) - LW'(1);
                        w_pend_n  = &w_is_long;
                        w_kept1_n = 1'b0;
                        w_state_n = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        w_stall = 1'b1;
                        w_cnt_n = r_cnt - LW'(1);
                    end else begin
                        // Result cycle for the lane currently on the unit.
                        w_cap1 = (r_cur == LANE1);
                        w_cap2 = (r_cur == LANE2);
                        if (r_pend) begin
                            // Hand the unit straight to lane 2.
                            w_stall   = 1'b1;
                            w_start   = 1'b1;
                            w_uop     = w_op[1];
                            w_usel    = 1'b1;
                            w_cnt_n   = w_lat[1] - LW'(1);
                            w_cur_n   = LANE2;
                            w_pend_n  = 1'b0;
                            w_kept1_n = 1'b1;
                        end else begin
                            // Release: requests seen now belong to this bundle.
                            w_use_kept1 = r_kept1;
                            w_kept1_n   = 1'b0;
                            w_state_n   = S_IDLE;
                        end
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // State and bookkeeping registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cur      <= LANE1;
            r_pend     <= 1'b0;
            r_kept1    <= 1'b0;
            r_fstalled <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_cur      <= w_cur_n;
            r_pend     <= w_pend_n;
            r_kept1    <= w_kept1_n;
            r_fstalled <= w_stall;
        end
    end

    assign bus.stall          = w_stall;
    assign bus.unit_start     = w_start;
    assign bus.unit_op        = w_uop;
    assign bus.unit_sel       = w_usel;
    assign bus.cap1           = w_cap1;
    assign bus.cap2           = w_cap2;
    assign bus.use_kept1      = w_use_kept1;
    assign bus.read_data_keep = w_rdk;
    assign bus.fstalled       = r_fstalled;
endmodule

// File: tb/tb_fpu_longop_scheduler.sv
// Bundle-level bench: each E bundle is expanded into its expected output
// timeline from the op latencies (start/capture/release cycles), with
// optional abort or reset landing at a chosen cycle of the bundle.
module tb_fpu_longop_scheduler;
    import fpu_pkg::*;

    localparam int DL = 3;
    localparam int SL = 2;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fpu_longop_scheduler_if #(.CW(CW)) bus ();

    fpu_longop_scheduler #(
        .DIV_LAT  (DL),
        .SQRT_LAT (SL),
        .CW       (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    logic prev_stall = 1'b0;

    function automatic int lat_of(input logic [4:0] c);
        if (c == 5'b00111) return DL;
        if (c == 5'b01101) return SL;
        return 0;
    endfunction

    // {stall, unit_start, unit_op, unit_sel, cap1, cap2, use_kept1, read_data_keep, fstalled}
    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.stall, bus.unit_start, bus.unit_op, bus.unit_sel, bus.cap1,
               bus.cap2, bus.use_kept1, bus.read_data_keep, bus.fstalled};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // kind: 0 none, 1 abort, 2 reset; kill_at = bundle cycle it lands on
    task automatic run_bundle(input string name, input logic [4:0] c1, input logic [4:0] c2,
                              input int kill_at, input int kind);
        int   l1, l2, tt;
        bit   both, killed;
        logic st, us, uo, usl, cp1, cp2, uk, rdk;
        l1   = lat_of(c1);
        l2   = lat_of(c2);
        tt   = l1 + l2;
        both = (l1 > 0) && (l2 > 0);
        for (int t = 0; t <= tt; t++) begin
            killed      = (kind != 0) && (kill_at == t);
            bus.fpuctl1 = (killed && kind == 2) ? FMOV : c1;
            bus.fpuctl2 = (killed && kind == 2) ? FMOV : c2;
            bus.abort   = killed && (kind == 1);
            rstn        = !(killed && kind == 2);
            @(negedge clk);
            st = 0; us = 0; uo = 0; usl = 0; cp1 = 0; cp2 = 0; uk = 0; rdk = 0;
            if (!killed && tt > 0) begin
                st  = (t < tt);
                rdk = (t == 0);
                if (t == 0) begin
                    us  = 1'b1;
                    usl = (l1 == 0);
                    uo  = (l1 > 0) ? (c1 == 5'b01101) : (c2 == 5'b01101);
                end else if (both && t == l1) begin
                    us  = 1'b1;
                    usl = 1'b1;
                    uo  = (c2 == 5'b01101);
                end
                cp1 = (l1 > 0) && (t == l1);
                cp2 = (l2 > 0) && (t == tt);
                uk  = both && (t == tt);
            end
            check($sformatf("%s c%0d", name, t), {st, us, uo, usl, cp1, cp2, uk, rdk, prev_stall});
            prev_stall = st;
            @(posedge clk);
            #1;
            if (killed) break;
        end
    endtask

    logic [4:0] r1, r2;
    int         kk, kat;

    initial begin
        rstn        = 1'b0;
        bus.fpuctl1 = FDIV;
        bus.fpuctl2 = FSQRT;
        bus.abort   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_hold", 9'b0);
        bus.fpuctl1 = FMOV;
        bus.fpuctl2 = FMOV;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_idle", 9'b0);
        @(posedge clk);
        #1;

        run_bundle("idle",        FADD,  FMUL,  -1, 0);
        run_bundle("l1_fdiv",     FDIV,  FMOV,  -1, 0);
        run_bundle("l2_fsqrt",    FMOV,  FSQRT, -1, 0);
        run_bundle("dual",        FDIV,  FSQRT, -1, 0);
        run_bundle("b2b_a",       FDIV,  FMOV,  -1, 0);
        run_bundle("b2b_b",       FDIV,  FMOV,  -1, 0);
        run_bundle("dual_sq_dv",  FSQRT, FDIV,  -1, 0);
        run_bundle("l2_fdiv",     FCMP,  FDIV,  -1, 0);
        run_bundle("abort_dual",  FDIV,  FSQRT,  1, 1);
        run_bundle("after_abort", FSQRT, FMOV,  -1, 0);
        run_bundle("abort_rel",   FDIV,  FMOV,   3, 1);
        run_bundle("reset_mid",   FDIV,  FMOV,   2, 2);
        run_bundle("after_reset", FDIV,  FSQRT, -1, 0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0:       r1 = FDIV;
                1:       r1 = FSQRT;
                2:       r1 = 5'($urandom_range(0, 31));
                default: r1 = FMOV;
            endcase
            case ($urandom_range(0, 3))
                0:       r2 = FDIV;
                1:       r2 = FSQRT;
                2:       r2 = 5'($urandom_range(0, 31));
                default: r2 = FMOV;
            endcase
            kk = $urandom_range(0, 9);
            kk = (kk == 0) ? 1 : (kk == 1) ? 2 : 0;
            kat = $urandom_range(0, lat_of(r1) + lat_of(r2));
            run_bundle($sformatf("rnd%0d", n), r1, r2, kat, kk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
